// File: rtl/bsg_adder_wallace_tree_accum.sv
`default_nettype none
// -----------------------------------------------------------------------------
// bsg_adder_wallace_tree_accum : Wallace-tree beat reduction + batch accumulator
// Revision: 1.0
// -----------------------------------------------------------------------------

module bsg_adder_wallace_tree #(
  parameter int width_p    = 8,
  parameter int capacity_p = 8
) (
  input  logic [capacity_p-1:0][width_p-1:0]    ops_i,
  output logic [width_p+$clog2(capacity_p)-1:0] resA_o,
  output logic [width_p+$clog2(capacity_p)-1:0] resB_o
);
  localparam int c_treeWidth = width_p + $clog2(capacity_p);

  if (capacity_p != 8 && capacity_p != 16 && capacity_p != 32) begin : g_badCapacity
    $error("bsg_adder_wallace_tree: capacity_p must be 8, 16 or 32");
  end

  // 3:2 carry-save layers until two rows remain. Carries past the top bit are
  // dropped: the true sum fits in c_treeWidth bits, so resA+resB mod 2^c_treeWidth is exact.
  always_comb begin
    logic [c_treeWidth-1:0] w_rows [capacity_p];
    logic [c_treeWidth-1:0] w_next [capacity_p];
    int n;
    int groups;
    for (int i = 0; i < capacity_p; i++) w_rows[i] = c_treeWidth'(ops_i[i]);
    n = capacity_p;
    for (int s = 0; s < capacity_p; s++) begin
      if (n > 2) begin
        w_next = w_rows;
        groups = n / 3;
        for (int g = 0; g < capacity_p / 3; g++) begin
          if (g < groups) begin
            w_next[2*g]   = w_rows[3*g] ^ w_rows[3*g+1] ^ w_rows[3*g+2];
            w_next[2*g+1] = ((w_rows[3*g] & w_rows[3*g+1]) |
                             (w_rows[3*g] & w_rows[3*g+2]) |
                             (w_rows[3*g+1] & w_rows[3*g+2])) << 1;
          end
        end
        for (int k = 0; k < 2; k++) begin
          if (k < n - 3*groups) w_next[2*groups+k] = w_rows[3*groups+k];
        end
        w_rows = w_next;
        n = 2*groups + (n - 3*groups);
      end
    end
    resA_o = w_rows[0];
    resB_o = w_rows[1];
  end
endmodule

module bsg_adder_wallace_tree_accum #(
  parameter int width_p       = 8,
  parameter int capacity_p    = 8,
  parameter int acc_width_p   = width_p + $clog2(capacity_p) + 8,
  parameter int count_width_p = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              v_i,
  input  logic [capacity_p-1:0][width_p-1:0] ops_i,
  input  logic                              last_i,
  output logic                              ready_o,
  output logic                              v_o,
  output logic [acc_width_p-1:0]            sum_o,
  output logic [count_width_p-1:0]          count_o,
  output logic                              overflow_o,
  input  logic                              yumi_i
);
  localparam int c_treeWidth = width_p + $clog2(capacity_p);

  localparam logic [1:0] c_stateAcc   = 2'd0;
  localparam logic [1:0] c_stateDrain = 2'd1;
  localparam logic [1:0] c_stateDone  = 2'd2;

  if (acc_width_p < c_treeWidth) begin : g_badAccWidth
    $error("bsg_adder_wallace_tree_accum: acc_width_p narrower than tree output");
  end

  logic [1:0]               r_state;
  logic                     r_s1Valid;
  logic                     r_s1Last;
  logic [c_treeWidth-1:0]   r_resA;
  logic [c_treeWidth-1:0]   r_resB;
  logic [acc_width_p-1:0]   r_acc;
  logic [count_width_p-1:0] r_count;
  logic                     r_overflow;

  logic [c_treeWidth-1:0]   w_treeA;
  logic [c_treeWidth-1:0]   w_treeB;
  logic [c_treeWidth-1:0]   w_beatSum;
  logic [acc_width_p:0]     w_accSum;
  logic                     w_accept;

  bsg_adder_wallace_tree #(
    .width_p    (width_p),
    .capacity_p (capacity_p)
  ) tree (
    .ops_i  (ops_i),
    .resA_o (w_treeA),
    .resB_o (w_treeB)
  );

  assign ready_o  = (r_state == c_stateAcc) && !reset_i;
  assign w_accept = v_i && ready_o;

  // Resolving the carry-save pair at tree width keeps any dropped tree carry out of the accumulator.
  assign w_beatSum = r_resA + r_resB;
  assign w_accSum  = {1'b0, r_acc} + {{(acc_width_p + 1 - c_treeWidth){1'b0}}, w_beatSum};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1Valid <= 1'b0;
      r_s1Last  <= 1'b0;
      r_resA    <= '0;
      r_resB    <= '0;
    end else begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Last <= last_i;
        r_resA   <= w_treeA;
        r_resB   <= w_treeB;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= c_stateAcc;
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        c_stateAcc:   if (w_accept && last_i) r_state <= c_stateDrain;
        c_stateDrain: if (r_s1Valid && r_s1Last) r_state <= c_stateDone;
        c_stateDone:  if (yumi_i) r_state <= c_stateAcc;
        default:      r_state <= c_stateAcc;
      endcase

      if (r_state == c_stateDone && yumi_i) begin
        r_acc      <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (r_s1Valid) begin
        r_acc      <= w_accSum[acc_width_p-1:0];
        r_overflow <= r_overflow | w_accSum[acc_width_p];
        if (r_count != {count_width_p{1'b1}}) r_count <= r_count + count_width_p'(1);
      end
    end
  end

  assign v_o        = (r_state == c_stateDone);
  assign sum_o      = r_acc;
  assign count_o    = r_count;
  assign overflow_o = r_overflow;

  a_yumiRequiresValid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("bsg_adder_wallace_tree_accum: yumi_i asserted while v_o=0");
endmodule
`default_nettype wire
